fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0: PC value loaded by reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h910003FF (ADDI X31,X31,#0): bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  64  current PC, driven to the combinational instruction memory.
REQ-006 imem_data  input  32  instruction at imem_addr, valid in the same cycle.
REQ-007 stall  input  1  hold PC and the IF/ID register for this cycle.
REQ-008 flush_id  input  1  load a bubble into IF/ID at the next edge.
REQ-009 take_branch  input  1  branch in ID resolved as taken this cycle.
REQ-010 br_uncond  input  1  1 = imm26 offset (B/BL); 0 = imm19 offset (CBZ/B.cond).
REQ-011 br_reg  input  1  1 = register target (BR); overrides br_uncond.
REQ-012 reg_target  input  64  forwarded register value for BR.
REQ-013 instr_id  output  32  IF/ID instruction.
REQ-014 pc_id  output  64  PC of instr_id.
REQ-015 pc_plus4_id  output  64  pc_id+4, used as the BL link value.
REQ-016 valid_id  output  1  instr_id is a real fetch, not a bubble.
REQ-017 fetch_count  output  32  number of fetches accepted into IF/ID.

Function
REQ-018 The PC register SHALL drive imem_addr directly, with no combinational path from the branch inputs.
REQ-019 Next-PC priority SHALL be: reset > stall (hold) > take_branch (target) > PC+4.
REQ-020 Branch target: br_reg=1 -> reg_target; otherwise pc_id + (sign-extended offset << 2).
REQ-021 The offset SHALL be instr_id[25:0] when br_uncond=1, else instr_id[23:5].
REQ-022 All address arithmetic SHALL be 64-bit modulo 2^64; wrap-around SHALL NOT be flagged.
REQ-023 One branch delay slot: the instruction fetched while the branch is in ID SHALL enter IF/ID normally.
REQ-024 IF/ID update on an edge:
- flush_id=1 -> {NOP_INSTR, valid 0}; flush_id wins over stall.
- else stall=1 -> hold.
- else -> {imem_data, PC, valid 1}.
REQ-025 On flush_id, pc_id and pc_plus4_id SHALL hold their previous values.
REQ-026 With stall=1 and take_branch=1 together, the branch SHALL be ignored this cycle; decode re-asserts it on the next cycle.
REQ-027 fetch_count SHALL increment by 1 on each edge that loads imem_data into IF/ID, and SHALL wrap from 2^32-1 to 0.
REQ-028 Latency: an instruction at PC p SHALL appear on instr_id one cycle after p is on imem_addr, provided there is no stall or flush.

Reset
REQ-029 While reset=1 at an edge: PC<=RESET_PC, instr_id<=NOP_INSTR, pc_id<=0, pc_plus4_id<=4, valid_id<=0, fetch_count<=0.
REQ-030 reset SHALL override stall, flush_id and take_branch.
REQ-031 Reset asserted mid-stall or mid-branch SHALL leave no residual state.
REQ-032 The first real fetch SHALL be RESET_PC, in the first cycle with reset=0.

Structure
REQ-033 Package cpu_pkg SHALL hold NOP_INSTR, RESET_PC, the PC width (64) and the instruction width (32).
REQ-034 Branch target computation SHALL be a sub-module, branch_target: pc, instr, br_uncond, br_reg, reg_target in; target out.
REQ-035 State elements SHALL use the team's d_ff_enable with SZ sized per field.

Verification
REQ-036 Reset held 2 cycles, then released; memory holds 0x91000421 at 0 -> imem_addr=0 in cycle 1; next cycle instr_id=0x91000421, pc_id=0, valid_id=1, fetch_count=1.
REQ-037 B with imm26=3 at PC 8, take_branch=1, br_uncond=1 -> PC sequence 8, 12, 20; instruction at 12 executes (delay slot).
REQ-038 CBZ with imm19=-2 at PC 0x40, take_branch=1, br_uncond=0 -> PC sequence 0x40, 0x44, 0x38.
REQ-039 stall=1 for 2 cycles with take_branch=1 asserted throughout -> PC and IF/ID frozen, fetch_count unchanged; branch takes effect in the first cycle after stall drops.
REQ-040 flush_id=1 and stall=1 together -> instr_id=0x910003FF, valid_id=0, PC held.
REQ-041 br_reg=1, reg_target=64'hFFFF_FFFF_FFFF_FFFC -> PC sequence ...FFFC, then 0 (wrap); fetch_count preset to 2^32-1 wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and the architectural reset/bubble values.
package cpu_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC  = 64'd0;
    // ADDI X31,X31,#0 -- architecturally a no-op, used as the IF/ID bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h910003FF;
endpackage

// File: rtl/branch_target.sv
// Branch target for the instruction sitting in ID: register target (BR) or
// PC-relative target from imm26 (B/BL) or imm19 (CBZ/B.cond), word-scaled.
module branch_target
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               br_uncond,
    input  logic               br_reg,
    input  logic [PC_W-1:0]    reg_target,
    output logic [PC_W-1:0]    target
);
    logic [PC_W-1:0] offset;
    logic            unused_opcode;

    // Opcode bits are decoded elsewhere; only the immediate fields matter here.
    assign unused_opcode = ^instr[31:26];

    // Sign-extend the selected immediate and scale by 4; register target wins.
    always_comb begin
        if (br_uncond) begin
            offset = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else begin
            offset = {{43{instr[23]}}, instr[23:5], 2'b00};
        end
        // Plain 64-bit add: wrap-around is intentional and unflagged.
        target = br_reg ? reg_target : (pc + offset);
    end
endmodule

// File: rtl/d_ff_enable.sv
// Generic register with synchronous active-high reset and load enable.
module d_ff_enable #(
    parameter int            SZ      = 1,
    parameter logic [SZ-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [SZ-1:0] d,
    output logic [SZ-1:0] q
);
    // Reset has priority over the load enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection with one branch
// delay slot, and the IF/ID pipeline register with stall/flush control.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    output logic [63:0]  imem_addr,
    input  logic [31:0]  imem_data,
    input  logic         stall,
    input  logic         flush_id,
    input  logic         take_branch,
    input  logic         br_uncond,
    input  logic         br_reg,
    input  logic [63:0]  reg_target,
    output logic [31:0]  instr_id,
    output logic [63:0]  pc_id,
    output logic [63:0]  pc_plus4_id,
    output logic         valid_id,
    output logic [31:0]  fetch_count
);
    logic [PC_W-1:0]    pc_q, pc_d, br_target;
    logic [INSTR_W-1:0] instr_d;
    logic               valid_d;
    logic [31:0]        count_d;
    logic               pc_en, ifid_en, load_en;

    // The PC register alone drives the memory address: no branch input reaches it combinationally.
    assign imem_addr = pc_q;

    // Target uses the IF/ID copy of the branch, so the instruction already being
    // fetched (the delay slot) still enters IF/ID normally.
    branch_target u_branch_target (
        .pc         (pc_id),
        .instr      (instr_id),
        .br_uncond  (br_uncond),
        .br_reg     (br_reg),
        .reg_target (reg_target),
        .target     (br_target)
    );

    // Next-PC: a stall freezes the PC (and drops a concurrent branch); otherwise branch target or sequential.
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (take_branch) begin
            pc_d = br_target;
        end
        pc_en = ~stall;
    end

    // IF/ID controls: flush loads a bubble even under stall; a real load needs neither.
    always_comb begin
        ifid_en = flush_id | ~stall;
        load_en = ~flush_id & ~stall;
        instr_d = flush_id ? NOP_INSTR : imem_data;
        valid_d = ~flush_id;
        count_d = fetch_count + 32'd1;
    end

    d_ff_enable #(.SZ(PC_W), .RST_VAL(RESET_PC)) u_pc_ff (
        .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q)
    );

    d_ff_enable #(.SZ(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr_ff (
        .clk(clk), .reset(reset), .en(ifid_en), .d(instr_d), .q(instr_id)
    );

    d_ff_enable #(.SZ(1), .RST_VAL(1'b0)) u_valid_ff (
        .clk(clk), .reset(reset), .en(ifid_en), .d(valid_d), .q(valid_id)
    );

    // The PC fields keep their old values across a flush.
    d_ff_enable #(.SZ(PC_W), .RST_VAL(64'd0)) u_pc_id_ff (
        .clk(clk), .reset(reset), .en(load_en), .d(pc_q), .q(pc_id)
    );

    d_ff_enable #(.SZ(PC_W), .RST_VAL(64'd4)) u_pc4_id_ff (
        .clk(clk), .reset(reset), .en(load_en), .d(pc_q + 64'd4), .q(pc_plus4_id)
    );

    // Counts accepted fetches; wraps naturally at 2^32.
    d_ff_enable #(.SZ(32), .RST_VAL(32'd0)) u_count_ff (
        .clk(clk), .reset(reset), .en(load_en), .d(count_d), .q(fetch_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences,
// and randomized control against a behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h910003FF;
    localparam logic [31:0] MEMX = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset, stall, flush_id, take_branch, br_uncond, br_reg;
    logic [63:0] reg_target, imem_addr, pc_id, pc_plus4_id;
    logic [31:0] imem_data, instr_id, fetch_count;
    logic        valid_id;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [63:0] m_pc, m_pcid, m_pc4;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid;

    typedef struct {
        logic        st, fl, br, unc, rg;
        logic [63:0] tgt;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic [63:0] e_pcid;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t vecs[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush_id(flush_id), .take_branch(take_branch),
        .br_uncond(br_uncond), .br_reg(br_reg), .reg_target(reg_target),
        .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
        .valid_id(valid_id), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // combinational instruction memory
    always_comb begin
        if (imem_addr < 64'd4096) imem_data = mem[imem_addr[11:2]];
        else                      imem_data = MEMX;
    end

    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        if (a < 64'd4096) return mem[a[11:2]];
        return MEMX;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge worth of fetch-stage rules.
    task automatic model_step(input logic r, st, fl, br, unc, rg, input logic [63:0] tgt);
        longint      off;
        logic [63:0] nxt;
        logic [31:0] fetched;
        if (r) begin
            m_pc = 64'd0; m_instr = NOP; m_pcid = 64'd0; m_pc4 = 64'd4;
            m_valid = 1'b0; m_cnt = 32'd0;
            return;
        end
        fetched = mem_rd(m_pc);
        nxt = m_pc;
        if (!st) begin
            if (br) begin
                if (unc) begin
                    off = longint'(m_instr[25:0]);
                    if (off >= 64'sd33554432) off -= 64'sd67108864;
                end else begin
                    off = longint'(m_instr[23:5]);
                    if (off >= 64'sd262144) off -= 64'sd524288;
                end
                nxt = rg ? tgt : m_pcid + 64'(off * 4);
            end else begin
                nxt = m_pc + 64'd4;
            end
        end
        if (fl) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = fetched; m_pcid = m_pc; m_pc4 = m_pc + 64'd4;
            m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc = nxt;
    endtask

    // Drive one cycle: inputs at the falling edge, returns at the next falling edge.
    task automatic step(input logic r, st, fl, br, unc, rg, input logic [63:0] tgt);
        reset = r; stall = st; flush_id = fl; take_branch = br;
        br_uncond = unc; br_reg = rg; reg_target = tgt;
        @(posedge clk);
        model_step(r, st, fl, br, unc, rg, tgt);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".instr_id"}, {32'd0, instr_id}, {32'd0, m_instr});
        chk({tag, ".pc_id"}, pc_id, m_pcid);
        chk({tag, ".pc_plus4_id"}, pc_plus4_id, m_pc4);
        chk({tag, ".valid_id"}, {63'd0, valid_id}, {63'd0, m_valid});
        chk({tag, ".fetch_count"}, {32'd0, fetch_count}, {32'd0, m_cnt});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, 64'd0);
        chk({tag, ".instr_id"}, {32'd0, instr_id}, {32'd0, NOP});
        chk({tag, ".pc_id"}, pc_id, 64'd0);
        chk({tag, ".pc_plus4_id"}, pc_plus4_id, 64'd4);
        chk({tag, ".valid_id"}, {63'd0, valid_id}, 64'd0);
        chk({tag, ".fetch_count"}, {32'd0, fetch_count}, 64'd0);
    endtask

    task automatic add_vec(input logic st, fl, br, unc, rg, input logic [63:0] tgt,
                           input logic [63:0] e_pc, input logic [31:0] e_instr,
                           input logic [63:0] e_pcid, input logic e_valid,
                           input logic [31:0] e_cnt);
        vec_t v;
        v.st = st; v.fl = fl; v.br = br; v.unc = unc; v.rg = rg; v.tgt = tgt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcid = e_pcid;
        v.e_valid = e_valid; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        logic st, fl, br, unc, rg, r;
        logic [63:0] tgt;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h9100_0000 | i;
        mem[0]  = 32'h91000421;   // first fetch
        mem[2]  = 32'h14000003;   // B +3 words at PC 8
        mem[16] = 32'hB4FFFFC0;   // CBZ imm19=-2 at PC 0x40

        //       st fl br unc rg tgt                    e_pc                   e_instr       e_pcid                 v  cnt
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'd4,                 32'h91000421, 64'd0,                 1, 1);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'd8,                 32'h91000001, 64'd4,                 1, 2);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'd12,                32'h14000003, 64'd8,                 1, 3);
        add_vec(0, 0, 1, 1, 0, 64'd0,                  64'd20,                32'h91000003, 64'd12,                1, 4);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'd24,                32'h91000005, 64'd20,                1, 5);
        add_vec(0, 0, 1, 0, 1, 64'h40,                 64'h40,                32'h91000006, 64'd24,                1, 6);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'h44,                32'hB4FFFFC0, 64'h40,                1, 7);
        add_vec(0, 0, 1, 0, 0, 64'd0,                  64'h38,                32'h91000011, 64'h44,                1, 8);
        add_vec(1, 0, 1, 0, 1, 64'h100,                64'h38,                32'h91000011, 64'h44,                1, 8);
        add_vec(1, 0, 1, 0, 1, 64'h100,                64'h38,                32'h91000011, 64'h44,                1, 8);
        add_vec(0, 0, 1, 0, 1, 64'h100,                64'h100,               32'h9100000E, 64'h38,                1, 9);
        add_vec(1, 1, 0, 0, 0, 64'd0,                  64'h100,               NOP,          64'h38,                0, 9);
        add_vec(0, 1, 0, 0, 0, 64'd0,                  64'h104,               NOP,          64'h38,                0, 9);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'h108,               32'h91000041, 64'h104,               1, 10);
        add_vec(0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 32'h91000042, 64'h108,           1, 11);
        add_vec(0, 0, 0, 0, 0, 64'd0,                  64'd0,                 MEMX,         64'hFFFF_FFFF_FFFF_FFFC, 1, 12);

        // reset held for two cycles
        step(1, 0, 0, 0, 0, 0, 64'd0);
        step(1, 0, 0, 0, 0, 0, 64'd0);
        check_reset_state("reset");

        foreach (vecs[k]) begin
            vec_t v;
            string tag;
            v = vecs[k];
            tag = $sformatf("vec%0d", k);
            step(0, v.st, v.fl, v.br, v.unc, v.rg, v.tgt);
            chk({tag, ".imem_addr"}, imem_addr, v.e_pc);
            chk({tag, ".instr_id"}, {32'd0, instr_id}, {32'd0, v.e_instr});
            chk({tag, ".pc_id"}, pc_id, v.e_pcid);
            chk({tag, ".pc_plus4_id"}, pc_plus4_id, v.e_pcid + 64'd4);
            chk({tag, ".valid_id"}, {63'd0, valid_id}, {63'd0, v.e_valid});
            chk({tag, ".fetch_count"}, {32'd0, fetch_count}, {32'd0, v.e_cnt});
        end

        // fetch_count wrap: preload all-ones, one real fetch must give zero
        force dut.u_count_ff.q = 32'hFFFF_FFFF;
        #1;
        release dut.u_count_ff.q;
        m_cnt = 32'hFFFF_FFFF;
        step(0, 0, 0, 0, 0, 0, 64'd0);
        chk("count_wrap", {32'd0, fetch_count}, 64'd0);
        check_model("after_wrap");

        // reset in the middle of a stalled branch and a flush leaves nothing behind
        step(0, 1, 0, 1, 1, 1, 64'h200);
        step(1, 1, 1, 1, 0, 1, 64'h200);
        check_reset_state("mid_reset");
        step(0, 0, 0, 0, 0, 0, 64'd0);
        chk("post_reset.instr", {32'd0, instr_id}, 64'h91000421);
        check_model("post_reset");

        // randomized control against the model
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 25);
            fl  = ($urandom_range(0, 99) < 15);
            br  = ($urandom_range(0, 99) < 25);
            unc = $urandom_range(0, 1);
            rg  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) tgt = {$urandom, $urandom};
            else                           tgt = 64'($urandom_range(0, 1023)) << 2;
            step(r, st, fl, br, unc, rg, tgt);
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
